udp_rx_port_filter: RTL
=======================

Name: udp_rx_port_filter

Overview:
- Byte-stream UDP header parser and payload gate. Sits after the IPv4 header receiver in the RX path.
- Parses the 8-byte UDP header and matches the destination port against NUM_PORTS programmable filters (or accepts any port in promiscuous mode).
- Exports header fields and a per-channel match index, then forwards the payload with valid/last framing.
- Adds length sanity checks, abort detection, padding discard and matched-channel reporting.

Parameters:
- NUM_PORTS, 4, number of destination-port filters (1..16).
- MAX_PAYLOAD, 1472, largest accepted payload in bytes; a larger UDP length is an error.
- CH_W, $clog2(NUM_PORTS) (min 1), width of the channel index.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset; synchronous, active-low.
- data_in  in  8  received byte.
- data_valid  in  1  byte qualifier; stays high for the whole frame, low between frames.
- ip_header_done  in  1  the byte on data_in this cycle is UDP header byte 0.
- port_d_list  in  16*NUM_PORTS  filter ports; entry i is in bits [16i+15:16i].
- port_en  in  NUM_PORTS  per-filter enable.
- promisc  in  1  accept any destination port.
- udp_port_s  out  16  captured source port.
- udp_port_d  out  16  captured destination port.
- udp_len  out  16  captured UDP length field.
- udp_chan  out  CH_W  matched filter index.
- udp_hit  out  1  a filter matched (0 = promiscuous accept with no match).
- hdr_valid  out  1  one-cycle pulse: header accepted, fields stable.
- udp_data  out  8  payload byte.
- udp_data_valid  out  1  payload byte qualifier.
- udp_data_tlast  out  1  last payload byte.
- err_len  out  1  one-cycle pulse: bad length.
- err_abort  out  1  one-cycle pulse: data_valid fell mid-frame.

Behaviour:
- Reset (aresetn=0 at a clock edge): state IDLE; all outputs 0; counters 0. Reset mid-frame drops the frame silently, with no error pulse.
- States: IDLE, HDR (byte counter 0..7), PAYLOAD, DISCARD.
- IDLE:
  - On data_valid=1 and ip_header_done=1, capture data_in as port_s[15:8] and go to HDR with count=1.
  - ip_header_done is ignored in every other state.
- HDR, bytes 1..7, big-endian:
  - Bytes 1: port_s low; 2-3: port_d; 4-5: length; 6-7: checksum (ignored, not verified).
- At byte 3, destination-port match:
  - hit_i = port_en[i] and port_d_list entry i == {port_d_hi, data_in}.
  - The lowest matching index wins and is loaded into udp_chan, with udp_hit=1.
  - No hit and promisc=0: go to DISCARD, no error.
  - No hit and promisc=1: continue with udp_chan=0, udp_hit=0.
- At byte 5, length check:
  - L={len_hi, data_in}.
  - L<8 or L-8>MAX_PAYLOAD: pulse err_len next cycle and go to DISCARD.
- At byte 7:
  - hdr_valid pulses the next cycle; udp_port_s/udp_port_d/udp_len/udp_chan/udp_hit hold until the next accepted header.
  - Payload length P=L-8 (16-bit unsigned). P=0: go to DISCARD. Otherwise go to PAYLOAD with remaining=P.
- PAYLOAD:
  - Each input byte is registered to udp_data with udp_data_valid=1 one cycle later (latency 1).
  - udp_data_tlast=1 coincides with the P-th byte output.
  - After the P-th byte, go to DISCARD; trailing bytes (Ethernet padding) are never forwarded.
- DISCARD: consume bytes until data_valid=0, then go to IDLE.
- data_valid=0 in HDR or PAYLOAD: pulse err_abort next cycle; no tlast is emitted; go to IDLE.
- data_valid=0 exactly one cycle after the final payload byte is sampled: normal completion, no error.
- Back-to-back frames: ip_header_done one cycle after data_valid returns high is honoured, since IDLE is reached when data_valid drops.
- udp_data_valid and udp_data_tlast are 0 whenever not in an active payload beat; udp_data holds its last value.

Test Plan:
- Port match: port_d_list={0x1234, 0x5000, 0x5000, 0}, port_en=4'b0111; header src 0xABCD, dst 0x5000, len 0x000C, then 4 payload bytes 11 22 33 44 -> hdr_valid once, udp_chan=1, udp_hit=1, udp_port_s=0xABCD; udp_data 11,22,33,44 on consecutive cycles; tlast only on 44.
- Miss and promiscuous: dst 0x9999, promisc=0 -> no hdr_valid, no data, no errors. Same frame with promisc=1 -> hdr_valid, udp_hit=0, udp_chan=0, payload forwarded.
- Length errors: len 0x0005 -> err_len single pulse, no hdr_valid. len = MAX_PAYLOAD+9 -> err_len. len 0x0008 -> hdr_valid, no udp_data_valid.
- Padding: len 0x000A (2 payload bytes) followed by 16 padding bytes -> exactly 2 valid bytes, tlast on the 2nd, padding dropped, no errors.
- Abort: data_valid falls after 3 of 10 payload bytes -> 3 valid bytes, no tlast, err_abort one pulse. Next frame parses normally.
- Reset mid-payload: aresetn=0 one cycle -> all outputs 0 next cycle, no err pulses; the following frame is received correctly.

Source files
------------

// File: rtl/udp_rx_port_filter.sv
// UDP header parser and destination-port filter for the RX path.
// Consumes one byte per cycle after the IPv4 header, exports header fields and gates the payload.
module udp_rx_port_filter #(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned MAX_PAYLOAD = 1472,
  parameter int unsigned CH_W        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [7:0]              data_in,
  input  logic                    data_valid,
  input  logic                    ip_header_done,
  input  logic [16*NUM_PORTS-1:0] port_d_list,
  input  logic [NUM_PORTS-1:0]    port_en,
  input  logic                    promisc,
  output logic [15:0]             udp_port_s,
  output logic [15:0]             udp_port_d,
  output logic [15:0]             udp_len,
  output logic [CH_W-1:0]         udp_chan,
  output logic                    udp_hit,
  output logic                    hdr_valid,
  output logic [7:0]              udp_data,
  output logic                    udp_data_valid,
  output logic                    udp_data_tlast,
  output logic                    err_len,
  output logic                    err_abort
);

  localparam int unsigned HDR_LEN   = 8;
  localparam int unsigned LEN_W     = 16;
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned LEN_MAX_I = MAX_PAYLOAD + HDR_LEN;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HDR     = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_DISCARD = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [LEN_W-1:0] cap_s, cap_s_nxt;
  logic [LEN_W-1:0] cap_d, cap_d_nxt;
  logic [LEN_W-1:0] cap_len, cap_len_nxt;
  logic [CH_W-1:0]  cap_chan, cap_chan_nxt;
  logic             cap_hit, cap_hit_nxt;
  logic [LEN_W-1:0] rem, rem_nxt;

  logic [15:0]      port_s_nxt, port_d_nxt, len_nxt;
  logic [CH_W-1:0]  chan_nxt;
  logic             hit_nxt, hdr_valid_nxt;
  logic [7:0]       data_nxt;
  logic             data_valid_nxt, tlast_nxt, err_len_nxt, err_abort_nxt;

  logic             match_hit;
  logic [CH_W-1:0]  match_chan;
  logic [LEN_W-1:0] len_full;
  logic             len_bad;

  // Lowest enabled filter equal to the destination port wins (descending loop, last write sticks).
  always_comb begin
    match_hit  = 1'b0;
    match_chan = '0;
    for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
      if (port_en[i] && (port_d_list[16*i +: 16] == {cap_d[15:8], data_in})) begin
        match_hit  = 1'b1;
        match_chan = CH_W'(i);
      end
    end
  end

  assign len_full = {cap_len[15:8], data_in};
  assign len_bad  = (len_full < LEN_W'(HDR_LEN)) || (32'(len_full) > LEN_MAX_I);

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    cap_s_nxt      = cap_s;
    cap_d_nxt      = cap_d;
    cap_len_nxt    = cap_len;
    cap_chan_nxt   = cap_chan;
    cap_hit_nxt    = cap_hit;
    rem_nxt        = rem;
    port_s_nxt     = udp_port_s;
    port_d_nxt     = udp_port_d;
    len_nxt        = udp_len;
    chan_nxt       = udp_chan;
    hit_nxt        = udp_hit;
    hdr_valid_nxt  = 1'b0;
    data_nxt       = udp_data;
    data_valid_nxt = 1'b0;
    tlast_nxt      = 1'b0;
    err_len_nxt    = 1'b0;
    err_abort_nxt  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (data_valid && ip_header_done) begin
          cap_s_nxt[15:8] = data_in;
          cnt_nxt         = CNT_W'(1);
          state_nxt       = ST_HDR;
        end
      end

      ST_HDR: begin
        if (!data_valid) begin
          err_abort_nxt = 1'b1;
          state_nxt     = ST_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
          case (cnt)
            3'd1: cap_s_nxt[7:0]  = data_in;
            3'd2: cap_d_nxt[15:8] = data_in;
            3'd3: begin
              cap_d_nxt[7:0] = data_in;
              cap_chan_nxt   = match_chan;
              cap_hit_nxt    = match_hit;
              if (!match_hit && !promisc) state_nxt = ST_DISCARD;
            end
            3'd4: cap_len_nxt[15:8] = data_in;
            3'd5: begin
              cap_len_nxt[7:0] = data_in;
              if (len_bad) begin
                err_len_nxt = 1'b1;
                state_nxt   = ST_DISCARD;
              end
            end
            3'd7: begin
              hdr_valid_nxt = 1'b1;
              port_s_nxt    = cap_s;
              port_d_nxt    = cap_d;
              len_nxt       = cap_len;
              chan_nxt      = cap_chan;
              hit_nxt       = cap_hit;
              rem_nxt       = cap_len - LEN_W'(HDR_LEN);
              state_nxt     = (cap_len == LEN_W'(HDR_LEN)) ? ST_DISCARD : ST_PAYLOAD;
            end
            default: ;
          endcase
        end
      end

      ST_PAYLOAD: begin
        if (!data_valid) begin
          err_abort_nxt = 1'b1;
          state_nxt     = ST_IDLE;
        end else begin
          data_nxt       = data_in;
          data_valid_nxt = 1'b1;
          tlast_nxt      = (rem == LEN_W'(1));
          rem_nxt        = rem - LEN_W'(1);
          // Anything after the last counted byte is link padding.
          if (rem == LEN_W'(1)) state_nxt = ST_DISCARD;
        end
      end

      ST_DISCARD: begin
        if (!data_valid) state_nxt = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      cap_s          <= '0;
      cap_d          <= '0;
      cap_len        <= '0;
      cap_chan       <= '0;
      cap_hit        <= 1'b0;
      rem            <= '0;
      udp_port_s     <= '0;
      udp_port_d     <= '0;
      udp_len        <= '0;
      udp_chan       <= '0;
      udp_hit        <= 1'b0;
      hdr_valid      <= 1'b0;
      udp_data       <= '0;
      udp_data_valid <= 1'b0;
      udp_data_tlast <= 1'b0;
      err_len        <= 1'b0;
      err_abort      <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      cap_s          <= cap_s_nxt;
      cap_d          <= cap_d_nxt;
      cap_len        <= cap_len_nxt;
      cap_chan       <= cap_chan_nxt;
      cap_hit        <= cap_hit_nxt;
      rem            <= rem_nxt;
      udp_port_s     <= port_s_nxt;
      udp_port_d     <= port_d_nxt;
      udp_len        <= len_nxt;
      udp_chan       <= chan_nxt;
      udp_hit        <= hit_nxt;
      hdr_valid      <= hdr_valid_nxt;
      udp_data       <= data_nxt;
      udp_data_valid <= data_valid_nxt;
      udp_data_tlast <= tlast_nxt;
      err_len        <= err_len_nxt;
      err_abort      <= err_abort_nxt;
    end
  end

endmodule
